pingpong_buf_ctrl: RTL and testbench

- Sequences the dual-bank ping-pong sample buffer of the spectrum analyzer.
- Generates write addresses for incoming audio samples and toggles the bank select after each full frame of DEPTH samples.
- Generates a burst of read addresses for the downstream FFT loader over the completed, idle bank.
- Flags frames lost to a slow reader (overrun).

---
 rtl/pingpong_buf_ctrl_if.sv | 30 +++
 rtl/pingpong_buf_ctrl.sv | 134 +++++++++++++
 tb/tb_pingpong_buf_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_buf_ctrl_if.sv
// Handshake bundle between the ping-pong buffer controller and its surroundings.
// The slave modport is the controller's view; master is the environment's view.
interface pingpong_buf_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  logic                 sample_valid_i;
  logic                 buff_sel_o;
  logic [ADDR_BITS-1:0] buff_waddr_o;
  logic [ADDR_BITS-1:0] buff_raddr_o;
  logic                 frame_ready_o;
  logic                 rd_req_i;
  logic                 rd_busy_o;
  logic                 rd_valid_o;
  logic                 rd_last_o;
  logic                 rd_abort_o;
  logic                 overrun_o;
  logic                 ovr_clr_i;

  modport master (
    output sample_valid_i, rd_req_i, ovr_clr_i,
    input  buff_sel_o, buff_waddr_o, buff_raddr_o, frame_ready_o,
           rd_busy_o, rd_valid_o, rd_last_o, rd_abort_o, overrun_o
  );

  modport slave (
    input  sample_valid_i, rd_req_i, ovr_clr_i,
    output buff_sel_o, buff_waddr_o, buff_raddr_o, frame_ready_o,
           rd_busy_o, rd_valid_o, rd_last_o, rd_abort_o, overrun_o
  );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong sample buffer sequencer: write addressing with bank swap per frame,
// read burst over the idle bank with RAM-latency-aligned valid, overrun/abort flags.
module pingpong_buf_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  pingpong_buf_ctrl_if.slave bus
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = '1;
  localparam logic [1:0]           DRAIN_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_e;

  rd_state_e              state_q, state_d;
  logic                   sel_q, sel_d;
  logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
  logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   abort_q, abort_d;
  logic [1:0]             drain_q, drain_d;
  logic [RD_LATENCY-1:0]  vpipe_q, vpipe_d;
  logic [RD_LATENCY-1:0]  lpipe_q, lpipe_d;

  logic swap, busy, accept, flush, issue, issue_last;

  assign swap       = bus.sample_valid_i && (waddr_q == LAST_ADDR);
  assign busy       = (state_q != IDLE);
  assign accept     = (state_q == IDLE) && bus.rd_req_i && pending_q && !swap;
  assign flush      = swap && busy;
  assign issue      = (state_q == READ);
  assign issue_last = issue && (raddr_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    drain_d   = drain_q;
    sel_d     = sel_q ^ swap;
    waddr_d   = bus.sample_valid_i ? waddr_q + 1'b1 : waddr_q;
    abort_d   = flush;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (swap) begin
      pending_d = 1'b1;
    end else if (accept) begin
      pending_d = 1'b0;
    end

    // A swap lands on a bank that still held an unread or partially read frame.
    if (swap && (pending_q || busy)) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr_i) begin
      overrun_d = 1'b0;
    end

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = READ;
            raddr_d = '0;
          end
        end
        READ: begin
          if (raddr_q == LAST_ADDR) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = IDLE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Valid/last follow each issued address by the RAM read latency; an abort empties the pipe.
  assign vpipe_d[0] = issue && !flush;
  assign lpipe_d[0] = issue_last && !flush;
  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
    assign vpipe_d[gi] = vpipe_q[gi-1] && !flush;
    assign lpipe_d[gi] = lpipe_q[gi-1] && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
      drain_q   <= '0;
      vpipe_q   <= '0;
      lpipe_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
      drain_q   <= drain_d;
      vpipe_q   <= vpipe_d;
      lpipe_q   <= lpipe_d;
    end
  end

  assign bus.buff_sel_o    = sel_q;
  assign bus.buff_waddr_o  = waddr_q;
  assign bus.buff_raddr_o  = raddr_q;
  assign bus.frame_ready_o = pending_q;
  assign bus.rd_busy_o     = busy;
  assign bus.rd_valid_o    = vpipe_q[RD_LATENCY-1];
  assign bus.rd_last_o     = lpipe_q[RD_LATENCY-1];
  assign bus.rd_abort_o    = abort_q;
  assign bus.overrun_o     = overrun_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Bench for pingpong_buf_ctrl: directed scenarios plus random traffic, checked against a
// time-arithmetic reference model and a read-burst scoreboard.
module tb_pingpong_buf_ctrl;
  localparam int AB    = 10;
  localparam int LAT   = 1;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pingpong_buf_ctrl_if #(.ADDR_BITS(AB)) bus ();

  pingpong_buf_ctrl #(.ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: burst progress is tracked as k = cycles since acceptance.
  int  m_waddr, m_raddr, m_k;
  bit  m_sel, m_pend, m_ovr, m_abort, m_active, model_ok;
  int  sb_q[$];

  initial begin
    model_ok = 0;
    forever begin
      bit sv, req, clr, swap, acc;
      @(posedge clk);
      sv  = bus.sample_valid_i;
      req = bus.rd_req_i;
      clr = bus.ovr_clr_i;
      if (rst) begin
        m_waddr = 0; m_raddr = 0; m_k = 0;
        m_sel = 0; m_pend = 0; m_ovr = 0; m_abort = 0; m_active = 0;
        sb_q.delete();
        model_ok = 1;
      end else if (model_ok) begin
        swap    = sv && (m_waddr == DEPTH - 1);
        acc     = !m_active && req && m_pend && !swap;
        m_abort = swap && m_active;
        if (swap && (m_pend || m_active)) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (swap) m_pend = 1;
        else if (acc) m_pend = 0;
        if (sv) m_waddr = (m_waddr + 1) % DEPTH;
        if (swap) m_sel = !m_sel;
        if (m_abort) begin
          m_active = 0;
          sb_q.delete();
        end else if (acc) begin
          m_active = 1;
          m_k = 1;
          for (int i = 0; i < DEPTH; i++) sb_q.push_back(i);
        end else if (m_active) begin
          m_k++;
          if (m_k > DEPTH + LAT) begin
            m_active = 0;
            check("sb_drained", sb_q.size(), 0);
          end
        end
        if (m_active) m_raddr = (m_k - 1 < DEPTH - 1) ? m_k - 1 : DEPTH - 1;
      end
    end
  end

  // Monitor: per-cycle compare against the model; scoreboard pop on every valid beat.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("sel",         bus.buff_sel_o,    m_sel);
        check("waddr",       bus.buff_waddr_o,  m_waddr);
        check("raddr",       bus.buff_raddr_o,  m_raddr);
        check("frame_ready", bus.frame_ready_o, m_pend);
        check("busy",        bus.rd_busy_o,     m_active);
        check("valid",       bus.rd_valid_o,    m_active && m_k >= 1 + LAT);
        check("last",        bus.rd_last_o,     m_active && m_k == DEPTH + LAT);
        check("abort",       bus.rd_abort_o,    m_abort);
        check("overrun",     bus.overrun_o,     m_ovr);
        if (bus.rd_valid_o === 1'b1) begin
          check("sb_nonempty", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            int idx;
            idx = sb_q.pop_front();
            check("sb_last", bus.rd_last_o, idx == DEPTH - 1);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.rd_busy_o !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", bus.rd_busy_o, 0);
  endtask

  initial begin
    int first_v, last_n, low_n, vcnt, abort_cnt, last_cnt, valid_cnt;
    rst = 1'b1;
    bus.sample_valid_i = 1'b0;
    bus.rd_req_i = 1'b0;
    bus.ovr_clr_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_sel", bus.buff_sel_o, 0);
    check("rst_waddr", bus.buff_waddr_o, 0);
    check("rst_raddr", bus.buff_raddr_o, 0);
    check("rst_ready", bus.frame_ready_o, 0);
    check("rst_ovr", bus.overrun_o, 0);

    // Frame 1: a strobe every 4 cycles.
    for (int i = 0; i < DEPTH; i++) begin
      check("t1_waddr_step", bus.buff_waddr_o, i);
      bus.sample_valid_i = 1'b1;
      tick();
      bus.sample_valid_i = 1'b0;
      if (i == DEPTH - 1) begin
        check("t1_sel", bus.buff_sel_o, 1);
        check("t1_ready", bus.frame_ready_o, 1);
        check("t1_waddr0", bus.buff_waddr_o, 0);
      end
      repeat (3) tick();
    end

    // Full burst timing.
    bus.rd_req_i = 1'b1;
    tick();
    bus.rd_req_i = 1'b0;
    check("t2_raddr0", bus.buff_raddr_o, 0);
    check("t2_ready_clr", bus.frame_ready_o, 0);
    first_v = -1; last_n = -1; low_n = -1; vcnt = 0;
    for (int n = 0; n < 1200; n++) begin
      if (n < DEPTH) check("t2_raddr", bus.buff_raddr_o, n);
      if (bus.rd_valid_o === 1'b1) begin
        vcnt++;
        if (first_v < 0) first_v = n;
      end
      if (bus.rd_last_o === 1'b1) last_n = n;
      if (bus.rd_busy_o === 1'b0) begin
        low_n = n;
        break;
      end
      tick();
    end
    check("t2_first_valid", first_v, LAT);
    check("t2_valid_cnt", vcnt, DEPTH);
    check("t2_last_pos", last_n, DEPTH - 1 + LAT);
    check("t2_busy_low", low_n, DEPTH + LAT);

    // Two unread frames -> overrun, then clear.
    bus.sample_valid_i = 1'b1;
    repeat (2 * DEPTH) tick();
    bus.sample_valid_i = 1'b0;
    check("t3_ovr", bus.overrun_o, 1);
    check("t3_sel", bus.buff_sel_o, 1);
    check("t3_ready", bus.frame_ready_o, 1);
    bus.ovr_clr_i = 1'b1;
    tick();
    bus.ovr_clr_i = 1'b0;
    check("t3_ovr_clr", bus.overrun_o, 0);

    // Swap in the middle of a burst -> abort.
    abort_cnt = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      bus.sample_valid_i = (i < DEPTH);
      bus.rd_req_i = (i == 300);
      tick();
      if (bus.rd_abort_o === 1'b1) begin
        abort_cnt++;
        check("t4_valid_drop", bus.rd_valid_o, 0);
        check("t4_busy_drop", bus.rd_busy_o, 0);
      end
    end
    bus.sample_valid_i = 1'b0;
    bus.rd_req_i = 1'b0;
    check("t4_abort_cnt", abort_cnt, 1);
    check("t4_ovr", bus.overrun_o, 1);
    check("t4_ready", bus.frame_ready_o, 1);

    // Request held across a swap with nothing pending.
    bus.rd_req_i = 1'b1;
    tick();
    bus.rd_req_i = 1'b0;
    wait_idle(1200);
    bus.sample_valid_i = 1'b1;
    repeat (DEPTH - 1) tick();
    bus.rd_req_i = 1'b1;
    tick();
    bus.sample_valid_i = 1'b0;
    check("t5_no_acc_busy", bus.rd_busy_o, 0);
    check("t5_no_acc_ready", bus.frame_ready_o, 1);
    tick();
    bus.rd_req_i = 1'b0;
    check("t5_acc_busy", bus.rd_busy_o, 1);
    check("t5_acc_ready", bus.frame_ready_o, 0);
    wait_idle(1200);

    // Clear coinciding with an overrun set: set wins.
    bus.ovr_clr_i = 1'b1;
    tick();
    bus.ovr_clr_i = 1'b0;
    check("t5b_ovr_clr", bus.overrun_o, 0);
    bus.sample_valid_i = 1'b1;
    repeat (DEPTH) tick();
    check("t5b_no_ovr", bus.overrun_o, 0);
    repeat (DEPTH - 1) tick();
    bus.ovr_clr_i = 1'b1;
    tick();
    bus.sample_valid_i = 1'b0;
    bus.ovr_clr_i = 1'b0;
    check("t5b_set_wins", bus.overrun_o, 1);

    // Reset mid-burst and mid-frame.
    bus.rd_req_i = 1'b1;
    tick();
    bus.rd_req_i = 1'b0;
    for (int n = 0; n < 500; n++) begin
      bus.sample_valid_i = (n >= 200);
      tick();
    end
    bus.sample_valid_i = 1'b0;
    check("t6_raddr500", bus.buff_raddr_o, 500);
    check("t6_waddr300", bus.buff_waddr_o, 300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_sel", bus.buff_sel_o, 0);
    check("t6_waddr", bus.buff_waddr_o, 0);
    check("t6_raddr", bus.buff_raddr_o, 0);
    check("t6_ready", bus.frame_ready_o, 0);
    check("t6_busy", bus.rd_busy_o, 0);
    check("t6_valid", bus.rd_valid_o, 0);
    check("t6_ovr", bus.overrun_o, 0);
    last_cnt = 0; abort_cnt = 0; valid_cnt = 0;
    for (int n = 0; n < 1100; n++) begin
      if (bus.rd_last_o === 1'b1) last_cnt++;
      if (bus.rd_abort_o === 1'b1) abort_cnt++;
      if (bus.rd_valid_o === 1'b1) valid_cnt++;
      tick();
    end
    check("t6_no_last", last_cnt, 0);
    check("t6_no_abort", abort_cnt, 0);
    check("t6_no_valid", valid_cnt, 0);

    // Random traffic against the model.
    for (int n = 0; n < 8000; n++) begin
      bus.sample_valid_i = ($urandom_range(0, 3) != 0);
      bus.rd_req_i       = ($urandom_range(0, 7) == 0);
      bus.ovr_clr_i      = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.sample_valid_i = 1'b0;
    bus.rd_req_i = 1'b0;
    bus.ovr_clr_i = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
